// File: rtl/toggle_pulse_gen.sv
// Push-button conditioner: two-flop synchroniser, debounce counter and a
// press / hold / repeat FSM that emits one registered T_out pulse per accepted event.
module toggle_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic       Clock,
    input  logic       Clear_b,
    input  logic       Key_in,
    input  logic       Repeat_en,
    output logic       T_out,
    output logic       Key_state,
    output logic [1:0] dbg_state
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic             REL_LVL     = (KEY_ACTIVE_LOW != 0);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_HELD      = 2'd1,
        ST_REPEATING = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              key_state_q, key_state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              t_out_q, t_out_d;

    logic pressed;
    logic press_evt;
    logic release_evt;
    logic tmr_hit;

    // Synchroniser and debounce: the level flips on the edge the count would reach DEBOUNCE_CYCLES
    always_comb begin
        sync1_d     = Key_in;
        sync2_d     = sync1_q;
        pressed     = REL_LVL ? ~sync2_q : sync2_q;
        db_cnt_d    = '0;
        key_state_d = key_state_q;
        if (pressed != key_state_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_state_d = ~key_state_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_evt   = key_state_d & ~key_state_q;
        release_evt = ~key_state_d & key_state_q;
    end

    always_ff @(posedge Clock or negedge Clear_b) begin
        if (!Clear_b) begin
            sync1_q     <= REL_LVL;
            sync2_q     <= REL_LVL;
            db_cnt_q    <= '0;
            key_state_q <= 1'b0;
            tmr_q       <= '0;
            t_out_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_cnt_q    <= db_cnt_d;
            key_state_q <= key_state_d;
            tmr_q       <= tmr_d;
            t_out_q     <= t_out_d;
        end
    end

    always_ff @(posedge Clock or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q <= ST_RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    // Release takes priority over a timer expiry on the same edge
    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        unique case (state_q)
            ST_RELEASED: begin
                if (press_evt) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (release_evt) begin
                    state_d = ST_RELEASED;
                end else if (Repeat_en) begin
                    if (tmr_q == DELAY_LAST) state_d = ST_REPEATING;
                    else                     tmr_d   = tmr_q + 1'b1;
                end
            end
            ST_REPEATING: begin
                if (release_evt) begin
                    state_d = ST_RELEASED;
                end else if (!Repeat_en) begin
                    state_d = ST_HELD;
                end else if (tmr_q != PERIOD_LAST) begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    always_comb begin
        tmr_hit = ((state_q == ST_HELD)      && (tmr_q == DELAY_LAST)) ||
                  ((state_q == ST_REPEATING) && (tmr_q == PERIOD_LAST));
        t_out_d = 1'b0;
        if (state_q == ST_RELEASED) begin
            t_out_d = press_evt;
        end else if (!release_evt && Repeat_en && tmr_hit) begin
            t_out_d = 1'b1;
        end
    end

    assign T_out     = t_out_q;
    assign Key_state = key_state_q;
    assign dbg_state = state_q;

endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
Upstream conditioning stage for the board's toggle flip-flop. It takes a raw, bouncing push-button level and synchronises and debounces it. It then emits a clean single-cycle toggle-enable pulse, T_out, per press, with optional auto-repeat while the button is held. T_out drives the T input of the downstream toggle flop directly, in the same Clock domain.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change (20 ms at 50 MHz); must be >= 1
REPEAT_DELAY, 25000000, cycles from the first press pulse to the first auto-repeat pulse; must be >= 1
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses; must be >= 1
KEY_ACTIVE_LOW, 1, 1 = Key_in reads 0 when pressed (board KEY buttons); 0 = active-high (SW)

Ports:
Clock  input  1  system clock; all state updates on the rising edge
Clear_b  input  1  asynchronous, active-low reset
Key_in  input  1  raw button level, asynchronous to Clock, may bounce
Repeat_en  input  1  1 = auto-repeat while held; 0 = one pulse per press
T_out  output  1  registered single-cycle toggle pulse, feeds downstream T input
Key_state  output  1  registered debounced level, 1 = pressed

Behaviour:
- Reset (Clear_b=0, no clock needed):
  - T_out=0, Key_state=0, all counters 0, FSM=RELEASED.
  - Both synchroniser flops go to the released raw level (1 if KEY_ACTIVE_LOW, else 0).
- Synchroniser: two-flop chain on Key_in. "Pressed sample" is the second flop, inverted when KEY_ACTIVE_LOW=1.
- Debounce counter:
  - Width is clog2(DEBOUNCE_CYCLES+1).
  - On each edge where the pressed sample != Key_state, the counter increments.
  - On each edge where the pressed sample == Key_state, the counter clears to 0.
  - When an increment would reach DEBOUNCE_CYCLES, Key_state flips on that edge and the counter clears.
- Latency: Key_in changes before edge k and stays stable; Key_state updates on edge k+1+DEBOUNCE_CYCLES. That is DEBOUNCE_CYCLES+2 edges after the change.
- FSM states and transitions:
  - RELEASED: on the edge Key_state goes 0->1, assert T_out for that one cycle, clear the repeat timer, and go to HELD.
  - HELD:
    - Key_state 1->0 -> RELEASED, no pulse on release.
    - Repeat_en=0 -> repeat timer held at 0.
    - Repeat_en=1 -> timer counts. On reaching REPEAT_DELAY cycles after the press pulse, pulse T_out, clear the timer, and go to REPEATING.
  - REPEATING:
    - Timer counts while Repeat_en=1. Every REPEAT_PERIOD cycles, pulse T_out and clear the timer.
    - Repeat_en=0 -> back to HELD with the timer cleared; re-enabling restarts the full REPEAT_DELAY.
    - Key_state 1->0 -> RELEASED.
  - Simultaneous release and timer expiry: release wins, no pulse.
- T_out rules:
  - Never high for two consecutive cycles.
  - Always coincident with a state-machine transition or a timer wrap.
  - Registered output, no combinational path from Key_in.
- Timer width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). It saturates logic-free because it clears on every expiry.
- Reset mid-operation: all state is lost.
  - If the key is still held after Clear_b deasserts, it is re-detected as a fresh press.
  - That gives one T_out, DEBOUNCE_CYCLES+2 edges after release of reset.
- Bench runs with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, KEY_ACTIVE_LOW=1.

Test Plan:
- Async reset: pulse Clear_b=0 between clock edges while holding a press -> T_out=0 and Key_state=0 immediately, before any edge.
- Clean press: Key_in 1->0 before edge k, held for 20 cycles, Repeat_en=0 -> T_out=1 only in the cycle after edge k+5, exactly 1 pulse total, Key_state=1 from edge k+5. Then Key_in 0->1 -> Key_state=0 at 6 edges later, no T_out.
- Bounce rejection: Key_in toggles every 2 cycles for 12 cycles, then returns to 1 -> T_out never asserts, Key_state stays 0. Then a 3-cycle low glitch also produces no pulse.
- Auto-repeat: Repeat_en=1, press held for 30 cycles after the first pulse -> pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28 from the first pulse (8 total), no two adjacent.
- Repeat enable edge cases:
  - Repeat_en dropped at offset 14 and raised at 17 -> no pulse until offset 27, then 30, 33, and so on.
  - Release coinciding with the offset-13 expiry -> no pulse at 13.
- Reset mid-repeat plus integration: Clear_b low for 2 cycles at offset 15 while held -> outputs 0; after reset, exactly one pulse 6 edges later. With T_out wired to the downstream toggle flop, Q toggles once per accepted pulse, counted and checked against a scoreboard.
